truth_table_scanner: RTL
========================

// Module: truth_table_scanner
// PURPOSE
//   Stimulus/capture stage that sits directly upstream of, and consumes the
//   output of, a combinational gate under test (f-series gate modules).
//   On a start pulse it walks vec_out through every input combination, holds
//   each for a settle window, samples the gate output into a truth-table
//   register, then compares it to an expected table. It replaces hand-written
//   #delay test sequences with a clocked, self-checking scan.
// PARAMETERS
//   N_IN    2        number of gate inputs; table width is 2**N_IN
//   SETTLE  1        idle cycles vec_out is held before sampling (0 allowed)
//   EXPECT  4'b1101  expected table, bit i = s for vec_out=i (s = a | ~b)
// PORTS
//   clk           in   1          rising-edge clock
//   reset         in   1          synchronous, active-high reset
//   start         in   1          request a full scan; sampled only in IDLE
//   gate_s        in   1          output of gate under test
//   vec_out       out  N_IN       gate inputs, MSB = a, LSB = b for N_IN=2
//   busy          out  1          high from DRIVE through DONE
//   done          out  1          one-cycle pulse, scan complete
//   table_out     out  2**N_IN    captured truth table, bit i for vector i
//   pass          out  1          table_out == EXPECT, valid from done on
//   mismatch_idx  out  N_IN       lowest index where table_out != EXPECT, else 0
// BEHAVIOUR
//   Reset (sync, wins over all): state=IDLE, idx=0, vec_out=0, busy=0, done=0,
//     table_out=0, pass=0, mismatch_idx=0. Mid-scan reset aborts; no done.
//   FSM states IDLE, DRIVE, SETTLE, SAMPLE, DONE; all outputs registered.
//   IDLE:   start=1 -> idx=0, table_out=0, pass=0, go DRIVE. start=0 -> stay.
//   DRIVE:  vec_out=idx; load settle count=SETTLE; go SETTLE (SAMPLE if
//           SETTLE==0). 1 cycle.
//   SETTLE: decrement count; stays exactly SETTLE cycles, then SAMPLE.
//   SAMPLE: at the closing edge, table_out[idx] <= gate_s. If
//           idx==2**N_IN-1, go DONE, else idx++ and go DRIVE.
//   DONE:   done=1 for this cycle only; pass and mismatch_idx are computed
//           from the final table at the edge entering DONE and held until
//           next start. Next edge -> IDLE.
//   vec_out stable for every cycle of DRIVE/SETTLE/SAMPLE of a vector; holds
//     last vector in DONE/IDLE until the next scan's first DRIVE.
//   Timing: per vector SETTLE+2 cycles; done is high in cycle
//     2**N_IN*(SETTLE+2)+1 counting the start-accept edge as edge 0.
//   start while busy (incl. DONE) is ignored; start held high re-arms in
//     IDLE, so back-to-back scans repeat every 2**N_IN*(SETTLE+2)+2 cycles.
//   table_out fills incrementally; only the done-cycle value is authoritative.
//   idx is N_IN+1 bits wide internally; it never wraps within a scan.
//   mismatch_idx: priority encode (table_out ^ EXPECT), lowest set bit wins.
// TESTING
//   1 reset=1 two cycles -> busy=0, done=0, vec_out=0, table_out=0, pass=0.
//   2 gate model s=a|~b, SETTLE=1, pulse start -> vec_out 0,1,2,3 each held
//     3 cycles; done in cycle 13; table_out=4'b1101, pass=1, mismatch_idx=0.
//   3 gate model NAND -> table_out=4'b0111, pass=0, mismatch_idx=1.
//   4 start held high, correct gate -> done pulses every 14 cycles, busy
//     low exactly 1 cycle (IDLE) between scans.
//   5 reset pulsed during vector 2 -> next cycle busy=0, table_out=0, no
//     done; subsequent start gives full correct scan, pass=1.
//   6 SETTLE=0 -> each vector held 2 cycles, done in cycle 9, pass=1.

Source files
------------

// File: rtl/truth_table_scanner.sv
// Clocked truth-table scanner for a combinational gate under test.
// Walks every input vector, samples the gate, and grades the table.
module truth_table_scanner #(
  parameter int N_IN = 2,
  parameter int SETTLE = 1,
  parameter logic [2**N_IN-1:0] EXPECT = 4'b1101
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              gate_s,
  output logic [N_IN-1:0]   vec_out,
  output logic              busy,
  output logic              done,
  output logic [2**N_IN-1:0] table_out,
  output logic              pass,
  output logic [N_IN-1:0]   mismatch_idx
);

  localparam int TW = 2**N_IN;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [N_IN:0] LAST = (N_IN+1)'(TW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [TW-1:0]   table_q, table_d;
  logic            pass_q, pass_d;
  logic [N_IN-1:0] mis_q, mis_d;

  function automatic logic [N_IN-1:0] low_idx(
    input logic [TW-1:0] v
  );
    low_idx = '0;
    for (int i = TW - 1; i >= 0; i--) begin
      if (v[i]) low_idx = N_IN'(i);
    end
  endfunction

  // Next-state and registered-output values for the scan sequence
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    table_d = table_q;
    pass_d  = pass_q;
    mis_d   = mis_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          table_d = '0;
          pass_d  = 1'b0;
          mis_d   = '0;
          vec_d   = '0;
          busy_d  = 1'b1;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        cnt_d   = CW'(SETTLE);
        state_d = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        table_d[idx_q[N_IN-1:0]] = gate_s;
        if (idx_q == LAST) begin
          done_d  = 1'b1;
          pass_d  = (table_d == EXPECT);
          mis_d   = low_idx(table_d ^ EXPECT);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + (N_IN+1)'(1);
          vec_d   = idx_d[N_IN-1:0];
          state_d = S_DRIVE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      pass_q  <= 1'b0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      pass_q  <= pass_d;
      mis_q   <= mis_d;
    end
  end

  assign vec_out      = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = table_q;
  assign pass         = pass_q;
  assign mismatch_idx = mis_q;

endmodule
